// File: rtl/pixbuf_stream_pkg.sv
// Shared definitions for the pixel-buffer stream reader.
// Default widths match the 32K x 8 on-chip pixel RAM.
package pixbuf_stream_pkg;

  localparam int ADDR_W_DEFAULT = 15;
  localparam int DATA_W_DEFAULT = 8;
  localparam int LEN_W_DEFAULT  = 16;

  // Transfer sequencing: IDLE waits for start, RUN issues reads,
  // DRAIN waits for the FIFO to empty into the stream.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pixbuf_stream_fifo.sv
// Small first-word-fall-through FIFO between RAM read data and the stream.
// dout reads as zero while empty so the stream data bus is quiet when idle.
module pixbuf_stream_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when a pop frees a slot this cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pixbuf_stream_reader.sv
// Avalon-MM read master sweeping a linear pixel RAM range into an
// Avalon-ST packet. Reads are credit-limited so the output FIFO can
// never overflow regardless of downstream backpressure.
// Optional build macro PIXBUF_STREAM_READER_CHECKSUM_EN adds a 16-bit
// running sum of accepted pixels on port checksum.
module pixbuf_stream_reader
  import pixbuf_stream_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int LEN_W        = LEN_W_DEFAULT,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
`ifdef PIXBUF_STREAM_READER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_W-1:0]       base_reg;
  logic [LEN_W-1:0]        length_reg;
  logic [LEN_W-1:0]        issue_cnt_reg;
  logic [LEN_W-1:0]        out_cnt_reg;
  logic [READ_LATENCY-1:0] pipe_reg;
  logic [READ_LATENCY-1:0] pipe_next;
  logic                    done_reg;
  logic [SUM_W-1:0]        in_flight;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [DATA_W-1:0]       fifo_dout;
  logic                    start_accept;
  logic                    credit_ok;
  logic                    issue;
  logic                    last_pop;

  assign start_accept = (state_reg == IDLE) & start;
  assign fifo_pop     = ~fifo_empty & st_ready;
  assign fifo_push    = pipe_reg[READ_LATENCY-1];
  assign last_pop     = fifo_pop & (out_cnt_reg == length_reg - LEN_W'(1));

  // Reads currently travelling through the RAM pipeline.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + SUM_W'(pipe_reg[i]);
    end
  end

  // Credit: slots promised after this edge = count - pop + in_flight + issue.
  // Counting this cycle's pop keeps 1 pixel/cycle at the minimum FIFO depth.
  always_comb begin
    credit_ok = (SUM_W'(fifo_count) + in_flight - SUM_W'(fifo_pop)) < SUM_W'(FIFO_DEPTH);
  end

  // Issue one read per cycle while pixels remain and a FIFO slot is reserved.
  always_comb begin
    issue = (state_reg == RUN) && (issue_cnt_reg != length_reg) && credit_ok
            && (!fifo_full || fifo_pop);
  end

  // Read-valid shift register: stage 0 takes the issue, later stages shift.
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_next[gi] = issue;
    end else begin : g_tail
      assign pipe_next[gi] = pipe_reg[gi-1];
    end
  end

  // Pipeline register; reset discards any read data still in flight.
  always_ff @(posedge clk) begin
    if (reset) pipe_reg <= '0;
    else       pipe_reg <= pipe_next;
  end

  pixbuf_stream_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (m_readdata),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and bus-side outputs.
  always_comb begin
    state_next   = state_reg;
    busy         = (state_reg != IDLE);
    m_chipselect = issue;
    m_address    = '0;
    if (issue) begin
      m_address = base_reg + ADDR_W'(issue_cnt_reg);
    end
    case (state_reg)
      IDLE:    if (start && (length != '0)) state_next = RUN;
      RUN:     if (issue_cnt_reg == length_reg) state_next = DRAIN;
      DRAIN:   if (out_cnt_reg == length_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer parameters and issue/output counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_reg      <= '0;
      length_reg    <= '0;
      issue_cnt_reg <= '0;
      out_cnt_reg   <= '0;
    end else if (start_accept) begin
      base_reg      <= base_addr;
      length_reg    <= length;
      issue_cnt_reg <= '0;
      out_cnt_reg   <= '0;
    end else begin
      if (issue)    issue_cnt_reg <= issue_cnt_reg + LEN_W'(1);
      if (fifo_pop) out_cnt_reg   <= out_cnt_reg + LEN_W'(1);
    end
  end

  // done: cycle after the last accepted beat, or after a zero-length start.
  always_ff @(posedge clk) begin
    if (reset) done_reg <= 1'b0;
    else       done_reg <= (start_accept && (length == '0)) || last_pop;
  end

  assign done     = done_reg;
  assign m_write  = 1'b0;
  assign st_valid = ~fifo_empty;
  assign st_data  = fifo_dout;
  assign st_sop   = ~fifo_empty & (out_cnt_reg == '0);
  assign st_eop   = ~fifo_empty & (out_cnt_reg == length_reg - LEN_W'(1));

`ifdef PIXBUF_STREAM_READER_CHECKSUM_EN
  logic [15:0] checksum_reg;

  // Running mod-2^16 sum of accepted pixels; holds after done until next start.
  always_ff @(posedge clk) begin
    if (reset)             checksum_reg <= '0;
    else if (start_accept) checksum_reg <= '0;
    else if (fifo_pop)     checksum_reg <= checksum_reg + 16'(fifo_dout);
  end

  assign checksum = checksum_reg;
`else
  // No checksum port or adder in this build.
`endif

endmodule

// File: tb/tb_pixbuf_stream_reader.sv
// Scoreboard bench for pixbuf_stream_reader: stimulus pushes expected
// addresses and beats into queues, a negedge monitor pops and compares.
// Define PIXBUF_STREAM_READER_CHECKSUM_EN to also exercise the checksum.
module tb_pixbuf_stream_reader;

  localparam int L     = 1;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic        busy, done, m_chipselect, m_write;
  logic [14:0] m_address;
  logic [7:0]  m_readdata, st_data;
  logic        st_valid, st_ready, st_sop, st_eop;
`ifdef PIXBUF_STREAM_READER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t       exp_q[$];
  logic [14:0] addr_q[$];
  logic [7:0]  mem [32768];
  logic [7:0]  rd_pipe [L];
  int          tests_run = 0;
  int          fails = 0;
  int          cyc = 0;
  int          zl_cyc = -1;
  bit          mon_en = 0;
  bit          rand_ready = 0;
  bit          eop_prev = 0;
  bit          stall_prev = 0;
  logic [7:0]  stall_data = '0;
  int          beat_no = 0;

  always #5 clk = ~clk;

  pixbuf_stream_reader #(
    .READ_LATENCY (L),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_readdata   (m_readdata),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_sop       (st_sop),
    .st_eop       (st_eop)
`ifdef PIXBUF_STREAM_READER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  // Pixel RAM model with fixed read latency L.
  always @(posedge clk) begin
    rd_pipe[0] <= m_chipselect ? mem[m_address] : 8'h00;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m_readdata = rd_pipe[L-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: constant 1, or about 30% low when rand_ready is set.
  initial begin
    st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      st_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: addresses, beats, hold-under-stall, done timing, credit bound.
  always @(negedge clk) begin
    beat_t e;
    bit    xfer;
    bit    eop_now;
    bit    exp_done;
    int    occ;
    if (reset) begin
      eop_prev   = 0;
      stall_prev = 0;
    end else if (mon_en) begin
      eop_now = 0;
      xfer    = st_valid && st_ready;
      if (m_chipselect) begin
        if (addr_q.size() == 0) begin
          tests_run++; fails++;
          $display("FAIL m_address: unexpected read at %0h, none required", m_address);
        end else begin
          chk("m_address", 32'(m_address), 32'(addr_q.pop_front()));
        end
      end
      if (stall_prev) chk("stall_hold", {23'd0, st_valid, st_data}, {23'd0, 1'b1, stall_data});
      if (xfer) begin
        if (exp_q.size() == 0) begin
          tests_run++; fails++;
          $display("FAIL beat: unexpected beat data=%02h, none required", st_data);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] beat %0d data=%02h sop=%0d eop=%0d", beat_no, st_data, st_sop, st_eop);
          beat_no++;
          chk("beat{data,sop,eop}", 32'({st_data, st_sop, st_eop}), 32'(e));
          eop_now = e.eop;
        end
      end
      exp_done = eop_prev || (cyc == zl_cyc);
      if (done || exp_done) chk("done_timing", 32'(done), 32'(exp_done));
      if (busy) begin
        occ = int'(dut.fifo_count) + int'(dut.in_flight);
        tests_run++;
        if (occ > DEPTH) begin
          fails++;
          $display("FAIL credit: occupancy %0d, required at most %0d", occ, DEPTH);
        end
      end
      eop_prev   = xfer && eop_now;
      stall_prev = st_valid && !st_ready;
      stall_data = st_data;
    end
  end

  // Queue expectations, then pulse start for one cycle.
  task automatic start_xfer(input logic [14:0] b, input int len);
    beat_t       e;
    logic [14:0] a;
    for (int i = 0; i < len; i++) begin
      a      = b + 15'(i);
      e.data = mem[a];
      e.sop  = (i == 0);
      e.eop  = (i == len - 1);
      exp_q.push_back(e);
      addr_q.push_back(a);
    end
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    length    = 16'(len);
    @(posedge clk); #1;
    start = 1'b0;
    if (len == 0) zl_cyc = cyc;
  endtask

  // Wait (bounded) for done, then confirm nothing is left outstanding.
  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    chk({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_reads_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  task automatic idle_after(input string name);
    @(negedge clk);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    for (int i = 0; i < 32768; i++) mem[i] = i[7:0];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_st_valid", 32'(st_valid), 0);
    chk("rst_sop_eop", 32'({st_sop, st_eop}), 0);
    chk("rst_chipselect", 32'(m_chipselect), 0);
    chk("rst_m_write", 32'(m_write), 0);
    chk("rst_st_data", 32'(st_data), 0);
    chk("rst_m_address", 32'(m_address), 0);
`ifdef PIXBUF_STREAM_READER_CHECKSUM_EN
    chk("rst_checksum", 32'(checksum), 0);
`endif
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1;

    // Basic: 0x10..0x17, fill latency L+1 edges from the start edge.
    start_xfer(15'h0010, 8);
    @(negedge clk);
    chk("basic_busy", 32'(busy), 1);
    k = 0;
    while (!st_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("first_valid_latency", 32'(k), 32'(L + 1));
    chk("first_data", 32'(st_data), 32'h10);
    wait_done("basic");
    idle_after("basic");

    // Wrap-around at the top of the address space.
    start_xfer(15'h7FFE, 4);
    wait_done("wrap");
    idle_after("wrap");

    // Backpressure with pseudo-random ready.
    rand_ready = 1;
    start_xfer(15'h0200, 32);
    wait_done("backpressure");
    rand_ready = 0;
    idle_after("backpressure");

    // Zero length: done pulse, no beats, never busy.
    start_xfer(15'h0300, 0);
    wait_done("len0");
    chk("len0_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);

    // Single beat with sop and eop together.
    start_xfer(15'h0400, 1);
    wait_done("len1");
    idle_after("len1");

    // Start during RUN with different parameters is ignored.
    start_xfer(15'h0020, 16);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 15'h0100; length = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored_start");
    idle_after("ignored_start");

    // Reset mid-transfer, then a clean transfer.
    start_xfer(15'h0500, 32);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_st_valid", 32'(st_valid), 0);
    chk("midreset_chipselect", 32'(m_chipselect), 0);
    repeat (5) @(negedge clk);
    chk("midreset_no_done", 32'(done), 0);
    start_xfer(15'h0500, 5);
    wait_done("after_reset");
    idle_after("after_reset");

`ifdef PIXBUF_STREAM_READER_CHECKSUM_EN
    // 300 pixels of 0xFF: 300*255 = 76500 = 0x12AD4 -> 0x2AD4.
    for (int i = 0; i < 300; i++) mem[15'h1000 + i] = 8'hFF;
    start_xfer(15'h1000, 300);
    wait_done("checksum");
    chk("checksum_at_done", 32'(checksum), 32'h2AD4);
    repeat (3) @(negedge clk);
    chk("checksum_stable", 32'(checksum), 32'h2AD4);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
